// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port data RAM.
// The CPU load/store path and the DMA/loader path share the RAM. Each port uses a
// req/ack handshake, and only one transaction is in flight at a time. This block
// owns every RAM control signal.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t             state_q;
   logic               last_grant_q;  // 1 = DMA was granted last, 0 = CPU
   logic               port_q;        // port owning the transaction in flight (1 = DMA)
   logic               we_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               gnt_valid_d;
   logic               gnt_dma_d;
   logic               sel_we_d;
   logic [ADDR_W-1:0]  sel_addr_d;
   logic [DATA_W-1:0]  sel_wdata_d;

   // Round-robin pick and request mux. A tie goes to the port that was not served last.
   always_comb begin
      gnt_valid_d = cpu_req | dma_req;
      if (cpu_req && dma_req) begin
         gnt_dma_d = ~last_grant_q;
      end else if (dma_req) begin
         gnt_dma_d = 1'b1;
      end else begin
         gnt_dma_d = 1'b0;
      end
      if (gnt_dma_d) begin
         sel_we_d    = dma_we;
         sel_addr_d  = dma_addr;
         sel_wdata_d = dma_wdata;
      end else begin
         sel_we_d    = cpu_we;
         sel_addr_d  = cpu_addr;
         sel_wdata_d = cpu_wdata;
      end
   end

   // Sequencer FSM with registered RAM controls, acks, read data and busy.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         cnt_q        <= '0;
         cpu_ack      <= 1'b0;
         dma_ack      <= 1'b0;
         cpu_rdata    <= '0;
         dma_rdata    <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_write    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cpu_ack <= 1'b0;
               dma_ack <= 1'b0;
               if (gnt_valid_d) begin
                  port_q       <= gnt_dma_d;
                  last_grant_q <= gnt_dma_d;
                  we_q         <= sel_we_d;
                  mem_addr     <= sel_addr_d;
                  mem_wdata    <= sel_wdata_d;
                  mem_write    <= sel_we_d;
                  cnt_q        <= '0;
                  busy         <= 1'b1;
                  state_q      <= ACCESS;
               end else begin
                  state_q <= IDLE;
               end
            end
            ACCESS: begin
               if (we_q) begin
                  // A write needs exactly one cycle of mem_write.
                  mem_write <= 1'b0;
                  cpu_ack   <= ~port_q;
                  dma_ack   <= port_q;
                  state_q   <= RESP;
               end else if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                  // This is the last read-latency cycle, so RAM data is valid now.
                  if (port_q) begin
                     dma_rdata <= mem_rdata;
                  end else begin
                     cpu_rdata <= mem_rdata;
                  end
                  cpu_ack <= ~port_q;
                  dma_ack <= port_q;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RESP: begin
               cpu_ack   <= 1'b0;
               dma_ack   <= 1'b0;
               mem_write <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               busy      <= 1'b0;
               state_q   <= IDLE;
            end
            default: begin
               cpu_ack   <= 1'b0;
               dma_ack   <= 1'b0;
               mem_write <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               busy      <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Instance u_dut1 uses RD_LAT=1 and instance u_dut2
// uses RD_LAT=2. Both instances share the request inputs, and each one has its own RAM model.
module tb_dmem_arbiter;

   logic        clock;
   logic        reset;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

   logic        c1_ack, d1_ack, m1_write, busy1;
   logic [31:0] c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
   logic        c2_ack, d2_ack, m2_write, busy2;
   logic [31:0] c2_rdata, d2_rdata, m2_addr, m2_wdata, m2_rdata;

   logic [31:0] ram1 [0:255];
   logic [31:0] ram2 [0:255];

   int n_checks = 0;
   int n_fail   = 0;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut1 (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(c1_ack), .cpu_rdata(c1_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(d1_ack), .dma_rdata(d1_rdata),
      .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_write(m1_write), .mem_rdata(m1_rdata),
      .busy(busy1)
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) u_dut2 (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(c2_ack), .cpu_rdata(c2_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(d2_ack), .dma_rdata(d2_rdata),
      .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_write(m2_write), .mem_rdata(m2_rdata),
      .busy(busy2)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // RAM models: the write happens on a rising edge, and the read is combinational.
   initial begin
      for (int i = 0; i < 256; i++) begin
         ram1[i] = 32'hA000_0000 | i;
         ram2[i] = 32'hA000_0000 | i;
      end
   end
   always @(posedge clock) begin
      if (m1_write) ram1[m1_addr[7:0]] <= m1_wdata;
      if (m2_write) ram2[m2_addr[7:0]] <= m2_wdata;
   end
   assign m1_rdata = ram1[m1_addr[7:0]];
   assign m2_rdata = ram2[m2_addr[7:0]];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   int ack_t [3];
   int ack_p [3];
   int n_acks;
   int cnt;
   logic seen;

   initial begin
      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
      tick();
      tick();
      // Reset state
      check("rst_cpu_ack",   {63'd0, c1_ack},   64'd0);
      check("rst_dma_ack",   {63'd0, d1_ack},   64'd0);
      check("rst_cpu_rdata", {32'd0, c1_rdata}, 64'd0);
      check("rst_dma_rdata", {32'd0, d1_rdata}, 64'd0);
      check("rst_mem_addr",  {32'd0, m1_addr},  64'd0);
      check("rst_mem_wdata", {32'd0, m1_wdata}, 64'd0);
      check("rst_mem_write", {63'd0, m1_write}, 64'd0);
      check("rst_busy",      {63'd0, busy1},    64'd0);
      reset = 1'b0;

      // Test 1: CPU write to 0x10
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h0000_00f5;
      tick();
      check("t1_acc_write", {63'd0, m1_write}, 64'd1);
      check("t1_acc_addr",  {32'd0, m1_addr},  64'h10);
      check("t1_acc_wdata", {32'd0, m1_wdata}, 64'hf5);
      check("t1_acc_ack",   {63'd0, c1_ack},   64'd0);
      check("t1_acc_busy",  {63'd0, busy1},    64'd1);
      tick();
      check("t1_resp_write", {63'd0, m1_write}, 64'd0);
      check("t1_resp_ack",   {63'd0, c1_ack},   64'd1);
      check("t1_resp_dack",  {63'd0, d1_ack},   64'd0);
      check("t1_rdata",      {32'd0, c1_rdata}, 64'd0);
      cpu_req = 1'b0;
      tick();
      check("t1_idle_ack",  {63'd0, c1_ack},  64'd0);
      check("t1_idle_busy", {63'd0, busy1},   64'd0);
      check("t1_idle_addr", {32'd0, m1_addr}, 64'd0);

      // Test 2: CPU read from 0x10 with RD_LAT=1
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
      tick();
      check("t2_acc_write", {63'd0, m1_write}, 64'd0);
      check("t2_acc_addr",  {32'd0, m1_addr},  64'h10);
      check("t2_acc_ack",   {63'd0, c1_ack},   64'd0);
      tick();
      check("t2_ack",   {63'd0, c1_ack},   64'd1);
      check("t2_rdata", {32'd0, c1_rdata}, 64'hf5);
      cpu_req = 1'b0;
      tick();
      check("t2_hold_rdata", {32'd0, c1_rdata}, 64'hf5);
      check("t2_idle_ack",   {63'd0, c1_ack},   64'd0);
      // A write leaves cpu_rdata unchanged.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h99;
      tick();
      tick();
      check("t2w_ack",   {63'd0, c1_ack},   64'd1);
      check("t2w_rdata", {32'd0, c1_rdata}, 64'hf5);
      cpu_req = 1'b0;
      tick();

      // Test 3: both ports request writes right after reset. CPU is served first,
      // and DMA is acked 3 cycles later.
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h11;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h30; dma_wdata = 32'h22;
      tick();
      check("t3_acc_addr",  {32'd0, m1_addr},  64'h20);
      check("t3_acc_wdata", {32'd0, m1_wdata}, 64'h11);
      tick();
      check("t3_cpu_ack", {63'd0, c1_ack}, 64'd1);
      check("t3_dma_ack", {63'd0, d1_ack}, 64'd0);
      cpu_req = 1'b0;
      cnt = 99;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (d1_ack && cnt == 99) cnt = k;
      end
      check("t3_dma_gap", cnt, 64'd3);
      dma_req = 1'b0;
      check("t3_ram_cpu", {32'd0, ram1[32'h20]}, 64'h11);
      check("t3_ram_dma", {32'd0, ram1[32'h30]}, 64'h22);

      // Test 4: both ports hold read requests for 12 cycles with RD_LAT=2 (u_dut2).
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h60;
      n_acks = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if ((c2_ack || d2_ack) && n_acks < 3) begin
            ack_t[n_acks] = k;
            ack_p[n_acks] = d2_ack ? 1 : 0;
            n_acks++;
         end
         if (c2_ack) check("t4_cpu_rdata", {32'd0, c2_rdata}, 64'hA000_0050);
         if (d2_ack) check("t4_dma_rdata", {32'd0, d2_rdata}, 64'hA000_0060);
         check("t4_no_double_ack", {63'd0, c2_ack & d2_ack}, 64'd0);
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      check("t4_n_acks", n_acks, 64'd3);
      if (n_acks == 3) begin
         check("t4_ack0_t", ack_t[0], 64'd3);
         check("t4_ack1_t", ack_t[1], 64'd7);
         check("t4_ack2_t", ack_t[2], 64'd11);
         check("t4_ack0_p", ack_p[0], 64'd0);
         check("t4_ack1_p", ack_p[1], 64'd1);
         check("t4_ack2_p", ack_p[2], 64'd0);
      end
      tick();
      tick();

      // Test 5: reset pulses during the ACCESS cycle of a DMA write.
      do_reset();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h70; dma_wdata = 32'h55;
      tick();
      check("t5_acc_write", {63'd0, m1_write}, 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check("t5_rst_write", {63'd0, m1_write}, 64'd0);
      check("t5_rst_busy",  {63'd0, busy1},    64'd0);
      check("t5_rst_dack",  {63'd0, d1_ack},   64'd0);
      #2;
      reset = 1'b0;
      dma_req = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         seen = seen | d1_ack;
      end
      check("t5_no_dack", {63'd0, seen}, 64'd0);
      check("t5_ram_untouched", {32'd0, ram1[32'h70]}, 64'hA000_0070);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
      tick();
      check("t5_tie_addr", {32'd0, m1_addr}, 64'h10);
      tick();
      check("t5_tie_cack",  {63'd0, c1_ack},   64'd1);
      check("t5_tie_dack",  {63'd0, d1_ack},   64'd0);
      check("t5_tie_rdata", {32'd0, c1_rdata}, 64'hf5);
      cpu_req = 1'b0;
      cnt = 99;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (d1_ack && cnt == 99) begin
            cnt = k;
            check("t5_dma_rdata", {32'd0, d1_rdata}, 64'h11);
         end
      end
      check("t5_dma_gap", cnt, 64'd3);
      dma_req = 1'b0;
      tick();

      // Test 6: DMA read from 0x30. dma_addr changes and dma_req drops after the grant.
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h30;
      tick();
      dma_addr = 32'h20;
      dma_req = 1'b0;
      #1;
      check("t6_addr_latched", {32'd0, m1_addr}, 64'h30);
      check("t6_acc_cack",     {63'd0, c1_ack},  64'd0);
      tick();
      check("t6_dack",  {63'd0, d1_ack},   64'd1);
      check("t6_cack",  {63'd0, c1_ack},   64'd0);
      check("t6_rdata", {32'd0, d1_rdata}, 64'h22);
      check("t6_cpu_rdata_kept", {32'd0, c1_rdata}, 64'hf5);
      tick();
      check("t6_idle_busy", {63'd0, busy1}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
